// File: rtl/inst_mem_loader_pkg.sv
// loader_pkg: shared state encoding, default widths and checksum helper for inst_mem_loader
package loader_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 20;
  typedef enum logic [2:0] {IDLE, HEADER, LOAD, CHECK, DONE, ERROR} loader_state_t;
  // Two's-complement negation; the checksum word must equal the negated running sum
  function automatic logic [63:0] twos_comp(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction
endpackage

// File: rtl/inst_mem_loader_checksum.sv
// loader_checksum: running modular sum of data words and trailing-word match test
module loader_checksum
  import loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] data,
  output logic              match
);
  logic [DATA_W-1:0] sum_q, sum_d;
  // next running sum: cleared, accumulated or held
  always_comb begin
    sum_d = clr ? '0 : acc_en ? sum_q + data : sum_q;
    match = data == DATA_W'(twos_comp(64'(sum_q)));
  end
  // sum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end
endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: streams a length-prefixed image into instruction memory; LOADER_CHECKSUM_EN adds a trailing checksum word
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);
  localparam logic [63:0] CAP = (64'd1 << ADDR_W) - 64'(BASE_ADDR);
  loader_state_t     state_q, state_d;
  logic [DATA_W-1:0] rem_q, rem_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d, words_q, words_d;
  logic              ready_q, ready_d, we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic              acc;
  assign acc = in_valid && ready_q;
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t END_ST = CHECK;
  logic cs_match;
  loader_checksum #(.DATA_W(DATA_W)) u_checksum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == HEADER),
    .acc_en (acc && state_q == LOAD),
    .data   (in_data),
    .match  (cs_match)
  );
`else
  localparam loader_state_t END_ST = DONE;
`endif
  // next state, memory write strobe and outputs derived from the next state
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        state_d = HEADER;
        words_d = '0;
      end
      HEADER: if (acc) begin
        rem_d   = in_data;
        state_d = in_data == '0 ? END_ST : 64'(in_data) > CAP ? ERROR : LOAD;
      end
      LOAD: if (acc) begin
        we_d    = 1'b1;
        addr_d  = ADDR_W'(BASE_ADDR) + words_q;
        wdata_d = in_data;
        words_d = words_q + ADDR_W'(1);
        rem_d   = rem_q - DATA_W'(1);
        state_d = rem_q == DATA_W'(1) ? END_ST : LOAD;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (acc) state_d = cs_match ? DONE : ERROR;
`endif
      default: state_d = IDLE;
    endcase
    ready_d = state_d inside {HEADER, LOAD, CHECK};
    hold_d  = state_d != DONE;
    done_d  = state_d == DONE;
    err_d   = state_d == ERROR;
  end
  // FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign in_ready     = ready_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign error        = err_q;
  assign words_loaded = words_q;
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed self-checking bench for inst_mem_loader (follows LOADER_CHECKSUM_EN)
module tb_inst_mem_loader;
  localparam int DW = 16;
  localparam int AW = 4;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  typedef logic [DW-1:0] word_q_t[$];
  logic clk, rst_n, start, in_valid, in_ready, mem_we, cpu_hold, done, error;
  logic [DW-1:0] in_data, mem_wdata;
  logic [AW-1:0] mem_addr, words_loaded;
  inst_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  int            wc[$];
  always @(negedge clk) if (mem_we) begin
    wa.push_back(mem_addr);
    wd.push_back(mem_wdata);
    wc.push_back(cyc);
  end
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [DW-1:0] w);
    bit ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      ok = in_ready;
      tick();
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask
  task automatic gap(input bit rnd);
    if (rnd) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask
  task automatic send_image(input word_q_t img, input logic [DW-1:0] cs, input bit rnd);
    gap(rnd);
    send(DW'(img.size()));
    foreach (img[i]) begin
      gap(rnd);
      send(img[i]);
    end
    if (CS) begin
      gap(rnd);
      send(cs);
    end
    in_valid = 1'b0;
  endtask
  task automatic pulse_start();
    wa.delete();
    wd.delete();
    wc.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask
  task automatic check_reset(input string p);
    check({p, "_in_ready"}, in_ready, 0);
    check({p, "_mem_we"}, mem_we, 0);
    check({p, "_mem_addr"}, mem_addr, 0);
    check({p, "_mem_wdata"}, mem_wdata, 0);
    check({p, "_cpu_hold"}, cpu_hold, 1);
    check({p, "_done"}, done, 0);
    check({p, "_error"}, error, 0);
    check({p, "_words"}, words_loaded, 0);
  endtask
  task automatic check_writes(input string p, input word_q_t img);
    check({p, "_nwrites"}, wa.size(), img.size());
    foreach (img[i]) if (i < wa.size()) begin
      check($sformatf("%s_addr%0d", p, i), wa[i], i);
      check($sformatf("%s_data%0d", p, i), wd[i], img[i]);
    end
  endtask
  function automatic logic [DW-1:0] neg_sum(input word_q_t img);
    logic [DW-1:0] s = '0;
    foreach (img[i]) s += img[i];
    return -s;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    word_q_t img, empty;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    empty = {};
    repeat (2) tick();
    check_reset("rst");
    rst_n = 1'b1;
    tick();
    img = {16'h1111, 16'h2222, 16'h3333};
    pulse_start();
    check("t1_ready_after_start", in_ready, 1);
    send_image(img, 16'h999A, 1'b0);
    check("t1_done", done, 1);
    check("t1_hold", cpu_hold, 0);
    check("t1_error", error, 0);
    check("t1_words", words_loaded, 3);
    check("t1_ready_drop", in_ready, 0);
    check("t1_last_we_with_done", mem_we, !CS);
    settle();
    check_writes("t1", img);
    if (wc.size() == 3) begin
      check("t1_b2b_1", wc[1] - wc[0], 1);
      check("t1_b2b_2", wc[2] - wc[0], 2);
    end
    pulse_start();
    check("t2_hold_reassert", cpu_hold, 1);
    check("t2_done_clear", done, 0);
    send_image(img, 16'h999B, 1'b0);
    settle();
    check("t2_error", error, CS);
    check("t2_hold", cpu_hold, CS);
    check("t2_done", done, !CS);
    check_writes("t2", img);
    pulse_start();
    send_image(empty, 16'h0000, 1'b0);
    check("t3_done", done, 1);
    check("t3_words", words_loaded, 0);
    settle();
    check("t3_nwrites", wa.size(), 0);
    pulse_start();
    send(16'd17);
    in_valid = 1'b0;
    check("t4_error", error, 1);
    check("t4_hold", cpu_hold, 1);
    check("t4_ready", in_ready, 0);
    settle();
    check("t4_nwrites", wa.size(), 0);
    img = {};
    for (int i = 0; i < 16; i++) img.push_back(DW'(i * 16'h0101 + 16'h0A0B));
    pulse_start();
    send_image(img, neg_sum(img), 1'b0);
    check("t4b_done", done, 1);
    check("t4b_error", error, 0);
    settle();
    check_writes("t4b", img);
    img = {};
    for (int i = 0; i < 5; i++) img.push_back(DW'($urandom));
    pulse_start();
    send_image(img, neg_sum(img), 1'b1);
    settle();
    check("t5_done", done, 1);
    check("t5_words", words_loaded, 5);
    check_writes("t5", img);
    img = {16'hA001, 16'hA002, 16'hA003, 16'hA004};
    pulse_start();
    send(16'd4);
    send(img[0]);
    send(img[1]);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("t6_mid");
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_image(img, neg_sum(img), 1'b0);
    settle();
    check("t6_done", done, 1);
    check("t6_words", words_loaded, 4);
    check_writes("t6", img);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
